// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller: fetches a two-word block on a miss and
// presents it to the cache as a single one-cycle fill write.
module icache_refill_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_miss,
  input  logic [31:0]      i_miss_pc,
  output logic             o_mem_req,
  output logic [31:0]      o_mem_addr,
  input  logic             i_mem_ready,
  input  logic [31:0]      i_mem_rdata,
  output logic             o_fill_valid,
  output logic [2:0]       o_fill_index,
  output logic [25:0]      o_fill_tag,
  output logic [63:0]      o_fill_data,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_refill_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ_LO = 2'd1,
    ST_REQ_HI = 2'd2,
    ST_FILL   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [31:0]      r_base;
  logic [31:0]      r_lo;
  logic [31:0]      r_hi;
  logic [CNT_W-1:0] r_count;
  logic             w_latch_base;
  logic             w_cap_lo;
  logic             w_cap_hi;
  logic             w_fill_done;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and datapath load enables
  always_comb begin
    w_next_state = r_state;
    w_latch_base = 1'b0;
    w_cap_lo     = 1'b0;
    w_cap_hi     = 1'b0;
    w_fill_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_miss) begin
          w_next_state = ST_REQ_LO;
          w_latch_base = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_REQ_LO: begin
        if (i_mem_ready) begin
          w_next_state = ST_REQ_HI;
          w_cap_lo     = 1'b1;
        end else begin
          w_next_state = ST_REQ_LO;
        end
      end
      ST_REQ_HI: begin
        if (i_mem_ready) begin
          w_next_state = ST_FILL;
          w_cap_hi     = 1'b1;
        end else begin
          w_next_state = ST_REQ_HI;
        end
      end
      ST_FILL: begin
        w_next_state = ST_IDLE;
        w_fill_done  = 1'b1;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Block base, captured beats and saturating refill counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_base  <= 32'd0;
      r_lo    <= 32'd0;
      r_hi    <= 32'd0;
      r_count <= '0;
    end else begin
      if (w_latch_base) begin
        r_base <= i_miss_pc & 32'hFFFF_FFF8;
      end
      if (w_cap_lo) begin
        r_lo <= i_mem_rdata;
      end
      if (w_cap_hi) begin
        r_hi <= i_mem_rdata;
      end
      if (w_fill_done && (r_count != {CNT_W{1'b1}})) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  // Request/fill strobes decoded from the state register only, so they never
  // depend on same-cycle inputs
  always_comb begin
    o_mem_req    = 1'b0;
    o_mem_addr   = 32'd0;
    o_fill_valid = 1'b0;
    case (r_state)
      ST_REQ_LO: begin
        o_mem_req  = 1'b1;
        o_mem_addr = r_base;
      end
      ST_REQ_HI: begin
        o_mem_req  = 1'b1;
        o_mem_addr = {r_base[31:3], 3'b100};
      end
      ST_FILL: begin
        o_fill_valid = 1'b1;
      end
      default: begin
        o_mem_req    = 1'b0;
        o_mem_addr   = 32'd0;
        o_fill_valid = 1'b0;
      end
    endcase
  end

  assign o_busy         = (r_state != ST_IDLE);
  assign o_fill_index   = r_base[5:3];
  assign o_fill_tag     = r_base[31:6];
  assign o_fill_data    = {r_hi, r_lo};
  assign o_refill_count = r_count;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level refill model.
module tb_icache_refill_ctrl;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          miss = 1'b0;
  logic [31:0]   miss_pc = 32'd0;
  logic          mem_ready = 1'b0;
  logic [31:0]   mem_rdata = 32'd0;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          fill_valid;
  logic [2:0]    fill_index;
  logic [25:0]   fill_tag;
  logic [63:0]   fill_data;
  logic          busy;
  logic [CW-1:0] refill_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  icache_refill_ctrl #(.CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .i_miss(miss), .i_miss_pc(miss_pc),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
    .o_fill_valid(fill_valid), .o_fill_index(fill_index),
    .o_fill_tag(fill_tag), .o_fill_data(fill_data),
    .o_busy(busy), .o_refill_count(refill_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Transaction model: an open refill with a count of accepted beats
  bit          m_active;
  int          m_beats;
  logic [31:0] m_base;
  logic [31:0] m_lo;
  logic [31:0] m_hi;
  int          m_count;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_beats  <= 0;
      m_base   <= 32'd0;
      m_lo     <= 32'd0;
      m_hi     <= 32'd0;
      m_count  <= 0;
    end else if (!m_active) begin
      if (miss) begin
        m_active <= 1'b1;
        m_beats  <= 0;
        m_base   <= miss_pc & ~32'h7;
      end
    end else if (m_beats < 2) begin
      if (mem_ready) begin
        if (m_beats == 0) m_lo <= mem_rdata;
        else              m_hi <= mem_rdata;
        m_beats <= m_beats + 1;
      end
    end else begin
      m_active <= 1'b0;
      if (m_count < (1 << CW) - 1) m_count <= m_count + 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (!reset) begin
      check("busy", 64'(busy), 64'(m_active));
      check("mem_req", 64'(mem_req), 64'(m_active && (m_beats < 2)));
      if (m_active && (m_beats < 2))
        check("mem_addr", 64'(mem_addr), 64'(m_base + 32'(m_beats) * 32'd4));
      check("fill_valid", 64'(fill_valid), 64'(m_active && (m_beats == 2)));
      if (m_active && (m_beats == 2)) begin
        check("fill_index", 64'(fill_index), 64'(m_base[5:3]));
        check("fill_tag", 64'(fill_tag), 64'(m_base[31:6]));
        check("fill_data", fill_data, {m_hi, m_lo});
      end
      check("refill_count", 64'(refill_count), 64'(m_count));
    end
  end

  logic        c_valid [8];
  logic [25:0] c_tag [8];

  function automatic logic hit(input logic [31:0] pc);
    return c_valid[pc[5:3]] && (c_tag[pc[5:3]] == pc[31:6]);
  endfunction

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    #2;
  endtask

  task automatic mem_drive();
    mem_rdata = mem_ready ? mem_word(mem_addr) : ~mem_word(mem_addr);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    miss = 1'b0;
    mem_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  int          fill_cyc;
  logic [63:0] got_data;
  int          fills;
  logic [2:0]  idx [2];
  logic [31:0] pc;

  initial begin
    #1 reset = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_fill_valid", 64'(fill_valid), 64'd0);
    check("rst_fill_index", 64'(fill_index), 64'd0);
    check("rst_fill_tag", 64'(fill_tag), 64'd0);
    check("rst_fill_data", fill_data, 64'd0);
    check("rst_count", 64'(refill_count), 64'd0);
    @(negedge clock);
    #2;
    reset = 1'b0;

    // Reset in the middle of the high-word request
    miss = 1'b1; miss_pc = 32'h300; mem_ready = 1'b1; mem_drive(); step();
    miss = 1'b0; mem_drive(); step();
    check("req_hi_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_mem_req", 64'(mem_req), 64'd0);
    check("midrst_fill_valid", 64'(fill_valid), 64'd0);
    check("midrst_count", 64'(refill_count), 64'd0);
    step();
    reset = 1'b0;
    step();
    check("post_rst_no_fill", 64'(fill_valid), 64'd0);
    miss = 1'b1; miss_pc = 32'h300;
    for (int k = 0; k < 4; k++) begin
      mem_drive(); step(); miss = 1'b0;
    end
    check("post_rst_count", 64'(refill_count), 64'd1);

    // Zero-wait refill of 0x44
    do_reset();
    miss = 1'b1; miss_pc = 32'h44; mem_ready = 1'b1; mem_drive(); step();
    check("zw_addr_lo", 64'(mem_addr), 64'h40);
    miss = 1'b0; mem_drive(); step();
    check("zw_addr_hi", 64'(mem_addr), 64'h44);
    mem_drive(); step();
    check("zw_fill_valid", 64'(fill_valid), 64'd1);
    check("zw_fill_index", 64'(fill_index), 64'd0);
    check("zw_fill_tag", 64'(fill_tag), 64'h1);
    check("zw_fill_data", fill_data, {mem_word(32'h44), mem_word(32'h40)});
    step();
    check("zw_fill_end", 64'(fill_valid), 64'd0);
    check("zw_count", 64'(refill_count), 64'd1);
    check("zw_idle", 64'(busy), 64'd0);

    // Stalled beats: 3 wait cycles low, 2 wait cycles high
    do_reset();
    miss = 1'b1; miss_pc = 32'h1238; mem_ready = 1'b1; step();
    miss = 1'b0; fill_cyc = 0; got_data = 64'd0;
    for (int k = 1; k <= 12; k++) begin
      if (fill_valid && fill_cyc == 0) begin
        fill_cyc = k;
        got_data = fill_data;
      end
      if (k == 2) check("stall_addr_lo", 64'(mem_addr), 64'h1238);
      if (k == 5) check("stall_addr_hi", 64'(mem_addr), 64'h123C);
      mem_ready = (k == 4) || (k == 7);
      mem_drive();
      step();
    end
    check("stall_fill_cycle", 64'(fill_cyc), 64'd8);
    check("stall_fill_data", got_data, {mem_word(32'h123C), mem_word(32'h1238)});

    // PC moves mid-refill
    do_reset();
    miss = 1'b1; miss_pc = 32'h100; mem_ready = 1'b1; mem_drive(); step();
    mem_drive(); step();
    miss_pc = 32'h2000; mem_drive(); step();
    check("pcchg_fill_valid", 64'(fill_valid), 64'd1);
    check("pcchg_fill_tag", 64'(fill_tag), 64'h4);
    check("pcchg_fill_index", 64'(fill_index), 64'd0);
    miss = 1'b0; step();

    // Counter saturation with back-to-back refills
    do_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 18 * 4; i++) begin
      miss = 1'b1; miss_pc = $urandom; mem_rdata = $urandom;
      step();
      if (i == 55) check("sat_count_14", 64'(refill_count), 64'd14);
      if (i == 59) check("sat_count_15", 64'(refill_count), 64'd15);
    end
    check("sat_count_final", 64'(refill_count), 64'd15);

    // Cache-driven misses: 0x00 then 0x08
    do_reset();
    for (int i = 0; i < 8; i++) c_valid[i] = 1'b0;
    pc = 32'h0; fills = 0; mem_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (fill_valid) begin
        if (fills < 2) idx[fills] = fill_index;
        fills++;
        c_valid[fill_index] = 1'b1;
        c_tag[fill_index] = fill_tag;
      end
      if (hit(pc) && pc == 32'h0) pc = 32'h8;
      miss = !hit(pc); miss_pc = pc;
      mem_drive();
      step();
    end
    check("b2b_fills", 64'(fills), 64'd2);
    check("b2b_idx0", 64'(idx[0]), 64'd0);
    check("b2b_idx1", 64'(idx[1]), 64'd1);

    // Randomized traffic with occasional asynchronous resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      miss = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) miss_pc = $urandom;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      step();
    end
    reset = 1'b0;
    miss = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of refill event counter.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 miss  input  1  instruction cache miss (cache stall), high = PC not present.
REQ-005 miss_pc  input  32  fetch PC causing the miss.
REQ-006 mem_req  output  1  instruction memory read request.
REQ-007 mem_addr  output  32  word address of current memory read.
REQ-008 mem_ready  input  1  memory beat accept; read data valid this cycle.
REQ-009 mem_rdata  input  32  memory read data.
REQ-010 fill_valid  output  1  one-cycle strobe: write fill_* into cache line.
REQ-011 fill_index  output  3  cache line index (block address bits [5:3]).
REQ-012 fill_tag  output  26  cache tag (block address bits [31:6]).
REQ-013 fill_data  output  64  block data, {word at base+4, word at base}.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 refill_count  output  CNT_W  number of completed refills, saturating.

Function
REQ-016 FSM states: IDLE, REQ_LO, REQ_HI, FILL; exactly one active.
REQ-017 IDLE: on rising edge with miss=1, latch base = {miss_pc[31:3],3'b000}, go REQ_LO; miss=0 stays IDLE.
REQ-018 REQ_LO: mem_req=1, mem_addr=base; on edge with mem_ready=1 capture mem_rdata as low word, go REQ_HI; else hold.
REQ-019 REQ_HI: mem_req=1, mem_addr=base+4; on edge with mem_ready=1 capture mem_rdata as high word, go FILL; else hold.
REQ-020 mem_addr stable and mem_req held high from first request cycle until beat accepted; no request withdrawal.
REQ-021 FILL: fill_valid=1 exactly one cycle; fill_index=base[5:3], fill_tag=base[31:6], fill_data={high,low}; next state IDLE.
REQ-022 mem_req=0 in IDLE and FILL; fill_valid=0 outside FILL.
REQ-023 fill_index/fill_tag/fill_data driven from latched registers, stable throughout FILL.
REQ-024 miss and miss_pc ignored outside IDLE; PC change mid-refill does not alter base.
REQ-025 Zero-wait memory (mem_ready=1 continuously): miss sampled edge N -> REQ_LO N+1, REQ_HI N+2, FILL N+3, IDLE N+4; miss penalty 4 cycles.
REQ-026 IDLE entered after FILL samples miss again; cache updated at FILL edge so a refilled PC yields no second refill.
REQ-027 refill_count increments by 1 at the edge leaving FILL; holds at all-ones (no wrap).
REQ-028 mem_rdata sampled only on accepted beats; values on non-ready cycles ignored.
REQ-029 busy = (state != IDLE), combinational from state register.

Reset
REQ-030 reset=1 forces state IDLE immediately, independent of clock, including mid-refill.
REQ-031 Reset values: mem_req=0, mem_addr=0, fill_valid=0, fill_index=0, fill_tag=0, fill_data=0, busy=0, refill_count=0, captured words=0.
REQ-032 Refill interrupted by reset produces no fill_valid pulse; after release, an asserted miss starts a fresh refill.

Verification
REQ-033 mem_ready=1, miss=1, miss_pc=0x0000_0044 one edge -> mem_addr 0x40 then 0x44, fill_valid one cycle at N+3, fill_index=0, fill_tag=0x000_0001, fill_data={rdata@0x44,rdata@0x40}, refill_count=1.
REQ-034 mem_ready low 3 cycles in REQ_LO, then high; low 2 cycles in REQ_HI -> mem_req/mem_addr stable throughout, only accepted beats captured, fill_valid at cycle 8 after miss.
REQ-035 miss_pc changed 0x100->0x2000 during REQ_HI -> fill_tag=0x4 (from 0x100), fill_index=0, mem_addr never 0x2000.
REQ-036 reset pulsed while in REQ_HI -> same cycle mem_req=0, busy=0, no fill_valid, refill_count unchanged at 0; new miss afterwards completes normally.
REQ-037 Drive 2^CNT_W+2 refills (CNT_W=4 instance) -> refill_count saturates at 0xF.
REQ-038 Back-to-back misses 0x00 then 0x08 (miss held high, drops one cycle after each fill) -> two refills, fill_index 0 then 1, no duplicate refill of 0x00.
